// File: rtl/dmem_wr_arbiter.sv
// Data-memory write-port arbiter: CPU stores have priority, button writes are
// buffered in a 2-entry FIFO, and a bounded-wait counter forces a button grant
// (stalling the CPU for one cycle) so buffered button events are never starved.
module dmem_wr_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [31:0] cpu_waddr,
  input  logic [31:0] cpu_wdata,
  input  logic        btn_we,
  input  logic [31:0] btn_waddr,
  input  logic [31:0] btn_wdata,
  output logic        cpu_stall,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        btn_pending,
  output logic        btn_drop
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Explicit encoding so the debug state can be observed unambiguously.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU    = 2'd1,
    BTN    = 2'd2,
    FORCED = 2'd3
  } grant_e;

  // Saturating wait-counter increment, clamped at MAX_WAIT.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= MAX_WAIT_C) ? MAX_WAIT_C : v + 4'd1;
  endfunction

  logic [31:0] fifo_addr [2];
  logic [31:0] fifo_data [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [3:0]  wait_cnt;
  grant_e      last_grant;
  grant_e      last_grant_nxt;

  logic        fifo_nonempty;
  logic        fifo_full;
  logic        force_grant;
  logic        grant_btn;
  logic        grant_cpu;
  logic        push;
  logic        pop;

  assign fifo_nonempty = (count != 2'd0);
  assign fifo_full     = (count == 2'd2);
  assign btn_pending   = fifo_nonempty;

  // Grant decision from registered state plus cpu_we; nothing is granted in reset.
  always_comb begin
    force_grant    = 1'b0;
    grant_btn      = 1'b0;
    grant_cpu      = 1'b0;
    last_grant_nxt = IDLE;
    if (!rst) begin
      force_grant = fifo_nonempty & cpu_we & (wait_cnt == MAX_WAIT_C);
      grant_btn   = fifo_nonempty & (~cpu_we | force_grant);
      grant_cpu   = cpu_we & ~force_grant;
    end
    if (force_grant)    last_grant_nxt = FORCED;
    else if (grant_btn) last_grant_nxt = BTN;
    else if (grant_cpu) last_grant_nxt = CPU;
    cpu_stall = force_grant;
    pop       = grant_btn;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push      = btn_we & ~rst & (~fifo_full | pop);
  end

  // Button FIFO storage, pointers and occupancy; also the overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_addr[0] <= '0;
      fifo_addr[1] <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      btn_drop     <= 1'b0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= btn_waddr;
        fifo_data[wr_ptr] <= btn_wdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      btn_drop <= btn_we & fifo_full & ~pop;
    end
  end

  // Bounded-wait counter: counts CPU grants that deferred a waiting FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (grant_btn || !fifo_nonempty) begin
      wait_cnt <= 4'd0;
    end else if (grant_cpu) begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

  // Registered RAM write port; address/data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= grant_btn | grant_cpu;
      if (grant_btn) begin
        mem_waddr <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end else if (grant_cpu) begin
        mem_waddr <= cpu_waddr;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  // Debug record of the previous cycle's arbitration outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDLE;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_wr_arbiter.sv
// Self-checking bench for dmem_wr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_dmem_wr_arbiter;

  localparam int MAX_WAIT = 4;
  localparam logic [1:0] LG_IDLE   = 2'd0;
  localparam logic [1:0] LG_CPU    = 2'd1;
  localparam logic [1:0] LG_BTN    = 2'd2;
  localparam logic [1:0] LG_FORCED = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [31:0] cpu_waddr;
  logic [31:0] cpu_wdata;
  logic        btn_we;
  logic [31:0] btn_waddr;
  logic [31:0] btn_wdata;
  logic        cpu_stall;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        btn_pending;
  logic        btn_drop;

  dmem_wr_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_we     (cpu_we),
    .cpu_waddr  (cpu_waddr),
    .cpu_wdata  (cpu_wdata),
    .btn_we     (btn_we),
    .btn_waddr  (btn_waddr),
    .btn_wdata  (btn_wdata),
    .cpu_stall  (cpu_stall),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .btn_pending(btn_pending),
    .btn_drop   (btn_drop)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: pending button writes as {addr, data}.
  logic [63:0] bq[$];
  int          m_wait;
  logic        e_we;
  logic [31:0] e_addr;
  logic [31:0] e_data;
  logic        e_drop;
  logic [1:0]  e_lg;
  logic        last_stall;
  logic [31:0] cur_caddr;
  logic [31:0] cur_cdata;
  logic [1:0]  lg_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational stall, advance the
  // model, then check all registered outputs just after the edge.
  task automatic do_cycle(input logic r, input logic cw, input logic [31:0] ca,
                          input logic [31:0] cd, input logic bw,
                          input logic [31:0] ba, input logic [31:0] bd);
    logic ne, frc, gb, gc;
    rst = r; cpu_we = cw; cpu_waddr = ca; cpu_wdata = cd;
    btn_we = bw; btn_waddr = ba; btn_wdata = bd;
    #1;
    ne  = (bq.size() > 0);
    frc = !r && ne && cw && (m_wait == MAX_WAIT);
    gb  = !r && ne && (!cw || frc);
    gc  = !r && cw && !frc;
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, frc});
    last_stall = frc;
    if (r) begin
      bq.delete();
      m_wait = 0;
      e_we = 1'b0; e_addr = '0; e_data = '0; e_drop = 1'b0; e_lg = LG_IDLE;
    end else begin
      e_we = gb || gc;
      if (gb) begin
        e_addr = bq[0][63:32];
        e_data = bq[0][31:0];
        void'(bq.pop_front());
      end else if (gc) begin
        e_addr = ca;
        e_data = cd;
      end
      if (gb || !ne)  m_wait = 0;
      else if (gc)    m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      e_drop = 1'b0;
      if (bw) begin
        if (bq.size() < 2) bq.push_back({ba, bd});
        else               e_drop = 1'b1;
      end
      e_lg = frc ? LG_FORCED : gb ? LG_BTN : gc ? LG_CPU : LG_IDLE;
    end
    @(posedge clk);
    #1;
    lg_obs = dut.last_grant;
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_waddr", mem_waddr, e_addr);
    chk("mem_wdata", mem_wdata, e_data);
    chk("btn_pending", {31'd0, btn_pending}, {31'd0, (bq.size() != 0)});
    chk("btn_drop", {31'd0, btn_drop}, {31'd0, e_drop});
    chk("last_grant", {30'd0, lg_obs}, {30'd0, e_lg});
  endtask

  task automatic idle_cycle(input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, bw, ba, bd);
  endtask

  // Continuous CPU store traffic; a stalled store is repeated unchanged.
  task automatic busy_cycle(input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    if (!last_stall) begin
      cur_caddr = $urandom;
      cur_cdata = $urandom;
    end
    do_cycle(1'b0, 1'b1, cur_caddr, cur_cdata, bw, ba, bd);
  endtask

  initial begin
    last_stall = 1'b0;
    cur_caddr = '0;
    cur_cdata = '0;
    m_wait = 0;

    // Reset with junk inputs and a button write that must be lost.
    do_cycle(1'b1, 1'b1, 32'h1234, 32'h5678, 1'b1, 32'hBAD0, 32'hBAD1);
    do_cycle(1'b1, 1'b1, 32'h9999, 32'hAAAA, 1'b0, 32'h0, 32'h0);
    do_cycle(1'b1, 1'b0, 32'hFFFF, 32'hEEEE, 1'b1, 32'hBAD2, 32'hBAD3);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_mem_waddr", mem_waddr, 32'd0);
    chk("reset_btn_pending", {31'd0, btn_pending}, 32'd0);
    for (int i = 0; i < 3; i++) idle_cycle(1'b0, 32'h0, 32'h0);

    // Lone CPU store.
    do_cycle(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    chk("cpu_store_addr", mem_waddr, 32'h10);
    chk("cpu_store_data", mem_wdata, 32'hDEADBEEF);
    idle_cycle(1'b0, 32'h0, 32'h0);

    // Lone button write.
    idle_cycle(1'b1, 32'h7F00, 32'h4);
    chk("btn_pending_set", {31'd0, btn_pending}, 32'd1);
    idle_cycle(1'b0, 32'h0, 32'h0);
    chk("btn_write_addr", mem_waddr, 32'h7F00);
    chk("btn_write_data", mem_wdata, 32'h4);
    idle_cycle(1'b0, 32'h0, 32'h0);

    // Starvation bound: forced grant after MAX_WAIT deferred cycles.
    busy_cycle(1'b1, 32'hB0, 32'hB1);
    for (int i = 1; i <= 4; i++) busy_cycle(1'b0, 32'h0, 32'h0);
    chk("starve_stall_pending", {31'd0, cpu_stall}, 32'd1);
    busy_cycle(1'b0, 32'h0, 32'h0);
    chk("starve_btn_addr", mem_waddr, 32'hB0);
    lg_obs = dut.last_grant;
    chk("starve_forced", {30'd0, lg_obs}, {30'd0, LG_FORCED});
    busy_cycle(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) idle_cycle(1'b0, 32'h0, 32'h0);

    // Overflow: third pulse into a full FIFO is dropped.
    busy_cycle(1'b1, 32'hC1, 32'd1);
    busy_cycle(1'b1, 32'hC2, 32'd2);
    busy_cycle(1'b1, 32'hC3, 32'd3);
    chk("overflow_drop", {31'd0, btn_drop}, 32'd1);
    for (int i = 0; i < 12; i++) busy_cycle(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) idle_cycle(1'b0, 32'h0, 32'h0);

    // Full FIFO with a push in the same cycle as the forced pop.
    busy_cycle(1'b1, 32'hD1, 32'd1);
    busy_cycle(1'b1, 32'hD2, 32'd2);
    for (int i = 0; i < 3; i++) busy_cycle(1'b0, 32'h0, 32'h0);
    busy_cycle(1'b1, 32'hD5, 32'd5);
    chk("full_pop_no_drop", {31'd0, btn_drop}, 32'd0);
    for (int i = 0; i < 12; i++) busy_cycle(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) idle_cycle(1'b0, 32'h0, 32'h0);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic r, cw, bw;
      r  = ($urandom_range(0, 99) == 0);
      bw = ($urandom_range(0, 9) < 4);
      if (last_stall) begin
        cw = 1'b1;
      end else begin
        cw = ($urandom_range(0, 9) < 7);
        cur_caddr = $urandom;
        cur_cdata = $urandom;
      end
      do_cycle(r, cw, cur_caddr, cur_cdata, bw, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_wr_arbiter.md
# dmem_wr_arbiter

Arbitrates the single data-memory write port between the CPU store path and the button input module's write requests. Button writes are buffered in a 2-entry FIFO and normally wait behind CPU stores. A bounded-wait counter forces a button grant and stalls the CPU for one cycle, so button events are never starved. The block sits between the CPU MEM stage, the button module and the data RAM write port.

## Interface

Parameters:
- MAX_WAIT, 4: number of consecutive cycles the FIFO head may be deferred by CPU stores before a forced grant; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_we  in  1  CPU store request; held stable while cpu_stall=1
- cpu_waddr  in  32  CPU store address
- cpu_wdata  in  32  CPU store data
- btn_we  in  1  button write request, single-cycle pulse
- btn_waddr  in  32  button write address
- btn_wdata  in  32  button write data
- cpu_stall  out  1  CPU must hold its store this cycle (combinational)
- mem_we  out  1  registered write enable to data RAM
- mem_waddr  out  32  registered write address
- mem_wdata  out  32  registered write data
- btn_pending  out  1  FIFO non-empty (registered state)
- btn_drop  out  1  one-cycle pulse: button write lost, FIFO full

## Operation

- FIFO: 2 entries of {addr, data}, with rd_ptr, wr_ptr and a 2-bit count. Push on btn_we; pop on button grant.
- Grant decision is combinational, from registered state plus cpu_we:
  - force = fifo_nonempty & cpu_we & (wait_cnt == MAX_WAIT)
  - grant_btn = fifo_nonempty & (~cpu_we | force)
  - grant_cpu = cpu_we & ~force
  - cpu_stall = force
- Output register:
  - grant_btn: mem_we=1 with the FIFO head addr/data.
  - grant_cpu: mem_we=1 with the cpu addr/data.
  - neither: mem_we=0; mem_waddr and mem_wdata hold their last value.
- wait_cnt (4 bits):
  - cleared on grant_btn or when the FIFO is empty;
  - incremented when fifo_nonempty & grant_cpu;
  - saturates at MAX_WAIT.
- State register last_grant ∈ {IDLE, CPU, BTN, FORCED}. It records the previous cycle's decision, used only for debug and verification.
  - Next state is FORCED if force, else BTN if grant_btn, else CPU if grant_cpu, else IDLE.
- Push/pop boundaries:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Full (count=2) with btn_we and no pop: write discarded, btn_drop=1 next cycle, FIFO contents unchanged.
  - Full with btn_we and a simultaneous pop: push accepted, no drop.
  - Pointers wrap modulo 2.
- Reset clears:
  - FIFO, pointers and count
  - wait_cnt
  - last_grant=IDLE
  - mem_we=0, mem_waddr=0, mem_wdata=0
  - btn_drop=0
- While rst=1, cpu_stall=0 and no grant takes effect. Entries buffered before reset are lost.

## Timing

- CPU store accepted at cycle N (cpu_stall=0): mem_we=1 at N+1.
- Button pulse at cycle N into an empty FIFO with cpu_we=0 at N+1: grant at N+1, mem_we=1 at N+2. Pushed data is never granted in its push cycle.
- Forced cycle: cpu_stall=1 in cycle N and the CPU repeats its store at N+1. wait_cnt=0 at N+1, so the CPU is granted at N+1 (unless it is idle).
  - Worst-case button latency with continuous CPU stores: push to mem_we = MAX_WAIT+2 cycles.
  - Maximum CPU stall: 1 cycle per MAX_WAIT+1 cycles.
- btn_pending and btn_drop are registered and valid one cycle after the causing edge.
- No combinational path from btn_* inputs to any output.

## Test plan

- Reset: drive junk inputs with rst=1 for 3 cycles. Require mem_we=0, mem_waddr=0, mem_wdata=0, cpu_stall=0, btn_pending=0. Push one button write during reset; it must never appear on mem_*.
- Lone CPU store: cpu_we=1, addr 0x10, data 0xDEADBEEF for 1 cycle. Next cycle mem_we=1, mem_waddr=0x10, mem_wdata=0xDEADBEEF; the following cycle mem_we=0.
- Lone button write: btn_we pulse, addr 0x7F00, data 0x4, CPU idle. Require btn_pending=1 next cycle, mem_we=1 with 0x7F00/0x4 two cycles after the pulse, then btn_pending=0.
- Starvation bound (MAX_WAIT=4): continuous cpu_we, button pulse at cycle 0.
  - CPU granted for cycles 1..4; cpu_stall=1 at cycle 5; button data on mem_* at cycle 6; CPU data again at cycle 7.
  - last_grant=FORCED at cycle 6.
- Overflow: CPU busy continuously, three button pulses at cycles 0, 1, 2 (data 1, 2, 3).
  - btn_drop=1 at cycle 3 only.
  - Entries 1 and 2 written in order under forced grants; 3 never written.
- Full with simultaneous pop: FIFO full, pulse data 5 in the same cycle as the forced pop. Require no btn_drop and data 5 eventually written, after the remaining entry.
